// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA job dispatcher and its solve timer.
package sha_pkg;

    localparam int MIDSTATE_W = 256;
    localparam int HEAD_W     = 512;
    localparam int NONCE_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FLUSH,
        SOLVE,
        REPORT
    } state_t;

    localparam logic [1:0] ST_FOUND     = 2'd0;
    localparam logic [1:0] ST_EXHAUSTED = 2'd1;
    localparam logic [1:0] ST_ABORTED   = 2'd2;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sha_solve_timer.sv
// Clearable, enabled, saturating up-counter shared by the flush and timeout phases.
module sha_solve_timer #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear wins over enable so a phase change can restart the count in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sha_job_dispatcher.sv
// Feeds mining jobs to the SHA solve block and returns one result per job.
// Optional SHA_JOB_STATS_EN adds saturating found/exhausted/aborted counters.
module sha_job_dispatcher
    import sha_pkg::*;
#(
    parameter int                   ID_W          = 8,
    parameter int                   FLUSH_CYCLES  = 72,
    parameter int                   TIMEOUT_W     = 40,
    parameter logic [TIMEOUT_W-1:0] SOLVE_TIMEOUT = 40'h40_0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [MIDSTATE_W-1:0] job_mid_state,
    input  logic [HEAD_W-1:0]     job_head_data,
    input  logic [ID_W-1:0]       job_id,
    input  logic                  job_abort,
    output logic [MIDSTATE_W-1:0] sha_mid_state,
    output logic [HEAD_W-1:0]     sha_head_data,
    output logic                  sha_load_state,
    output logic                  sha_solve_en,
    input  logic                  sha_flag,
    input  logic [NONCE_W-1:0]    sha_golden_nonce,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [1:0]            res_status,
    output logic [NONCE_W-1:0]    res_nonce,
    output logic [ID_W-1:0]       res_id,
    output state_t                dbg_state
`ifdef SHA_JOB_STATS_EN
    ,
    output logic [31:0]           stat_found,
    output logic [31:0]           stat_exhausted,
    output logic [31:0]           stat_aborted
`endif
);

    localparam logic [TIMEOUT_W-1:0] FLUSH_LAST = TIMEOUT_W'(FLUSH_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] SOLVE_LAST = SOLVE_TIMEOUT - TIMEOUT_W'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [MIDSTATE_W-1:0] r_mid_state;
    logic [HEAD_W-1:0]     r_head_data;
    logic [ID_W-1:0]       r_id;
    logic [1:0]            r_res_status;
    logic [NONCE_W-1:0]    r_res_nonce;
    logic [ID_W-1:0]       r_res_id;

    logic                  w_tmr_clr;
    logic                  w_tmr_en;
    logic [TIMEOUT_W-1:0]  w_count;
    logic                  w_capture;
    logic [1:0]            w_cap_status;
    logic [NONCE_W-1:0]    w_cap_nonce;
    logic                  w_job_fire;
    logic                  w_res_fire;

    // Both handshakes transfer on the rising edge where valid and ready are high together;
    // a valid side never waits on ready combinationally and holds its payload until transfer.
    assign w_job_fire = job_valid && job_ready;
    assign w_res_fire = res_valid && res_ready;

    sha_solve_timer #(
        .W(TIMEOUT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_count (w_count)
    );

    always_comb begin
        w_next_state = r_state;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;
        w_capture    = 1'b0;
        w_cap_status = ST_FOUND;
        w_cap_nonce  = '0;
        case (r_state)
            IDLE: begin
                if (w_job_fire) begin
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                w_tmr_clr    = 1'b1;
                w_next_state = FLUSH;
            end
            FLUSH: begin
                // Stale hits from the previous job may still be draining; flag is ignored here.
                w_tmr_en = 1'b1;
                if (job_abort) begin
                    w_capture    = 1'b1;
                    w_cap_status = ST_ABORTED;
                    w_next_state = REPORT;
                end else if (w_count == FLUSH_LAST) begin
                    w_tmr_clr    = 1'b1;
                    w_next_state = SOLVE;
                end
            end
            SOLVE: begin
                w_tmr_en = 1'b1;
                if (sha_flag) begin
                    w_capture    = 1'b1;
                    w_cap_status = ST_FOUND;
                    w_cap_nonce  = sha_golden_nonce;
                    w_next_state = REPORT;
                end else if (job_abort) begin
                    w_capture    = 1'b1;
                    w_cap_status = ST_ABORTED;
                    w_next_state = REPORT;
                end else if (w_count == SOLVE_LAST) begin
                    w_capture    = 1'b1;
                    w_cap_status = ST_EXHAUSTED;
                    w_next_state = REPORT;
                end
            end
            REPORT: begin
                if (w_res_fire) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mid_state  <= '0;
            r_head_data  <= '0;
            r_id         <= '0;
            r_res_status <= '0;
            r_res_nonce  <= '0;
            r_res_id     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_job_fire) begin
                r_mid_state <= job_mid_state;
                r_head_data <= job_head_data;
                r_id        <= job_id;
            end
            if (w_capture) begin
                r_res_status <= w_cap_status;
                r_res_nonce  <= w_cap_nonce;
                r_res_id     <= r_id;
            end
        end
    end

    assign job_ready      = (r_state == IDLE);
    assign res_valid      = (r_state == REPORT);
    assign sha_load_state = (r_state == FLUSH) || (r_state == SOLVE);
    assign sha_solve_en   = (r_state == FLUSH) || (r_state == SOLVE);
    assign sha_mid_state  = r_mid_state;
    assign sha_head_data  = r_head_data;
    assign res_status     = r_res_status;
    assign res_nonce      = r_res_nonce;
    assign res_id         = r_res_id;
    assign dbg_state      = r_state;

`ifdef SHA_JOB_STATS_EN
    logic [31:0] r_stat_found;
    logic [31:0] r_stat_exhausted;
    logic [31:0] r_stat_aborted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_found     <= '0;
            r_stat_exhausted <= '0;
            r_stat_aborted   <= '0;
        end else if (w_res_fire) begin
            if (r_res_status == ST_FOUND)     r_stat_found     <= sat_inc32(r_stat_found);
            if (r_res_status == ST_EXHAUSTED) r_stat_exhausted <= sat_inc32(r_stat_exhausted);
            if (r_res_status == ST_ABORTED)   r_stat_aborted   <= sat_inc32(r_stat_aborted);
        end
    end

    assign stat_found     = r_stat_found;
    assign stat_exhausted = r_stat_exhausted;
    assign stat_aborted   = r_stat_aborted;
`endif

endmodule

// File: tb/tb_sha_job_dispatcher.sv
// Bench for sha_job_dispatcher: directed and randomized jobs against a timeline-based reference model.
module tb_sha_job_dispatcher;
    import sha_pkg::*;

    localparam int FL = 72;
    localparam int TO = 16;
    localparam int NEVER = 1 << 30;

    logic         clk;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_mid_state;
    logic [511:0] job_head_data;
    logic [7:0]   job_id;
    logic         job_abort;
    logic [255:0] sha_mid_state;
    logic [511:0] sha_head_data;
    logic         sha_load_state;
    logic         sha_solve_en;
    logic         sha_flag;
    logic [31:0]  sha_golden_nonce;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_status;
    logic [31:0]  res_nonce;
    logic [7:0]   res_id;
    state_t       dbg_state;
`ifdef SHA_JOB_STATS_EN
    logic [31:0]  stat_found;
    logic [31:0]  stat_exhausted;
    logic [31:0]  stat_aborted;
    int           exp_found;
    int           exp_exhausted;
    int           exp_aborted;
`endif

    int n_checks;
    int n_errors;
    logic [41:0] exp_q[$];

    sha_job_dispatcher #(
        .ID_W          (8),
        .FLUSH_CYCLES  (FL),
        .TIMEOUT_W     (40),
        .SOLVE_TIMEOUT (40'd16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_mid_state    (job_mid_state),
        .job_head_data    (job_head_data),
        .job_id           (job_id),
        .job_abort        (job_abort),
        .sha_mid_state    (sha_mid_state),
        .sha_head_data    (sha_head_data),
        .sha_load_state   (sha_load_state),
        .sha_solve_en     (sha_solve_en),
        .sha_flag         (sha_flag),
        .sha_golden_nonce (sha_golden_nonce),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_status       (res_status),
        .res_nonce        (res_nonce),
        .res_id           (res_id),
        .dbg_state        (dbg_state)
`ifdef SHA_JOB_STATS_EN
        ,
        .stat_found       (stat_found),
        .stat_exhausted   (stat_exhausted),
        .stat_aborted     (stat_aborted)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: periods are counted from the cycle after the accept edge (period 0 is
    // the clear cycle, 1..FL flush, FL+1.. solve). The earliest qualifying event ends the job,
    // FOUND beating ABORTED beating EXHAUSTED on a tie; the result appears one period later.
    function automatic void predict(input int flag_s, input int abort_p,
                                    output int rep_p, output logic [1:0] st);
        int solve0;
        int t_found;
        int t_abort;
        int t_exh;
        solve0  = FL + 1;
        t_found = (flag_s >= 0 && flag_s < TO) ? solve0 + flag_s : NEVER;
        t_abort = (abort_p >= 1) ? abort_p : NEVER;
        t_exh   = solve0 + TO - 1;
        if (t_found <= t_abort && t_found <= t_exh) begin
            st = ST_FOUND;     rep_p = t_found + 1;
        end else if (t_abort <= t_exh) begin
            st = ST_ABORTED;   rep_p = t_abort + 1;
        end else begin
            st = ST_EXHAUSTED; rep_p = t_exh + 1;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"}, job_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_load"}, sha_load_state, 0);
        check({tag, "_solve_en"}, sha_solve_en, 0);
        check({tag, "_res"}, {res_status, res_nonce, res_id}, 0);
        check({tag, "_mid"}, sha_mid_state, 0);
        check({tag, "_head"}, sha_head_data, 0);
        check({tag, "_state"}, dbg_state, IDLE);
`ifdef SHA_JOB_STATS_EN
        check({tag, "_stats"}, {stat_found, stat_exhausted, stat_aborted}, 0);
`endif
    endtask

    // Driver: called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_job(input logic [7:0] id, input int flag_s, input logic [31:0] nonce,
                           input int abort_p, input int flush_flag_p, input int hold,
                           input bit next_pending);
        logic [255:0] ms;
        logic [511:0] hd;
        logic [41:0]  exp_r;
        logic [1:0]   st;
        int           rep_p;
        int           p;
        bit           seen;
        bit           flag_now;
        for (int i = 0; i < 8; i++)  ms[i*32 +: 32] = $urandom;
        for (int i = 0; i < 16; i++) hd[i*32 +: 32] = $urandom;
        predict(flag_s, abort_p, rep_p, st);
        exp_q.push_back({st, (st == ST_FOUND) ? nonce : 32'h0, id});

        check("job_ready_idle", job_ready, 1);
        job_valid = 1'b1;
        job_mid_state = ms;
        job_head_data = hd;
        job_id = id;
        p = 0;
        seen = 1'b0;
        while (!seen && p < FL + TO + 8) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
            end else begin
                if (p == 0) begin
                    job_valid = 1'b0;
                    check("clear_solve_en", sha_solve_en, 0);
                    check("clear_load", sha_load_state, 0);
                    check("busy_job_ready", job_ready, 0);
                end
                if (p == 1) begin
                    check("run_solve_en", sha_solve_en, 1);
                    check("run_load", sha_load_state, 1);
                end
                flag_now = (flag_s >= 0) && (p == FL + 1 + flag_s);
                sha_flag = flag_now || (p == flush_flag_p);
                sha_golden_nonce = flag_now ? nonce : $urandom;
                job_abort = (p == abort_p);
                p++;
            end
        end
        sha_flag = 1'b0;
        job_abort = 1'b0;
        check("res_valid_seen", seen, 1);
        check("report_period", p, rep_p);
        check("report_solve_en", sha_solve_en, 0);
        check("report_load", sha_load_state, 0);
        check("report_job_ready", job_ready, 0);
        check("mid_state", sha_mid_state, ms);
        check("head_data", sha_head_data, hd);
        exp_r = exp_q.pop_front();
        check("result", {res_status, res_nonce, res_id}, exp_r);

        for (int i = 0; i < hold; i++) begin
            job_valid = next_pending;
            job_abort = 1'($urandom_range(0, 1));
            sha_flag = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_result", {res_valid, res_status, res_nonce, res_id}, {1'b1, exp_r});
            check("hold_job_ready", job_ready, 0);
        end
        job_valid = next_pending;
        job_abort = 1'b0;
        sha_flag = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("post_res_valid", res_valid, 0);
        check("post_job_ready", job_ready, 1);
`ifdef SHA_JOB_STATS_EN
        if (st == ST_FOUND) exp_found++;
        if (st == ST_EXHAUSTED) exp_exhausted++;
        if (st == ST_ABORTED) exp_aborted++;
        check("stats", {stat_found, stat_exhausted, stat_aborted},
              {32'(exp_found), 32'(exp_exhausted), 32'(exp_aborted)});
`endif
    endtask

    task automatic reset_mid_solve(input logic [7:0] id);
        int n_res;
        check("rst_job_ready_idle", job_ready, 1);
        job_valid = 1'b1;
        job_mid_state = {8{$urandom}};
        job_head_data = {16{$urandom}};
        job_id = id;
        @(negedge clk);
        job_valid = 1'b0;
        repeat (FL + 4) @(negedge clk);
        check("rst_pre_solve_en", sha_solve_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        n_res = 0;
        repeat (FL + TO + 6) begin
            @(negedge clk);
            if (res_valid) n_res++;
        end
        check("no_result_after_rst", n_res, 0);
`ifdef SHA_JOB_STATS_EN
        exp_found = 0;
        exp_exhausted = 0;
        exp_aborted = 0;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        job_valid = 1'b0;
        job_mid_state = '0;
        job_head_data = '0;
        job_id = '0;
        job_abort = 1'b0;
        sha_flag = 1'b0;
        sha_golden_nonce = '0;
        res_ready = 1'b0;
`ifdef SHA_JOB_STATS_EN
        exp_found = 0;
        exp_exhausted = 0;
        exp_aborted = 0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // found 10 cycles into solve
        run_job(8'h05, 10, 32'h1DAC2B7C, -1, -1, 0, 1'b0);
        // flag pulse in flush is ignored, job runs out
        run_job(8'h11, -1, 32'h0, -1, 5, 0, 1'b0);
        // abort 3 cycles into solve
        run_job(8'h22, -1, 32'h0, FL + 1 + 3, -1, 0, 1'b0);
        // flag and abort together: found wins
        run_job(8'h33, 6, 32'hCAFE_F00D, FL + 1 + 6, -1, 0, 1'b0);
        // flag on the last solve cycle beats exhaustion
        run_job(8'h44, TO - 1, 32'h0BAD_BEEF, -1, -1, 0, 1'b0);
        // abort on the last solve cycle beats exhaustion
        run_job(8'h55, -1, 32'h0, FL + TO, -1, 0, 1'b0);
        // abort in flush, including a flush flag pulse
        run_job(8'h66, -1, 32'h0, 10, 3, 0, 1'b0);
        // consumer stalls 20 cycles with the next job already offered
        run_job(8'h77, 2, 32'h1234_5678, -1, -1, 20, 1'b1);
        run_job(8'h78, 0, 32'h8765_4321, -1, -1, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            int fs;
            int ap;
            fs = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO + 2));
            ap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, FL + TO + 2)) : -1;
            run_job(8'($urandom), fs, $urandom, ap, int'($urandom_range(1, FL)),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        reset_mid_solve(8'h99);
        run_job(8'hA0, 4, 32'h5555_AAAA, -1, -1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
